demux_stream_1ton: RTL and testbench
====================================

// Module: demux_stream_1ton
//
// PURPOSE
// Parametrised 1:N stream demultiplexer with per-channel output registers and
// valid/ready flow control. One input word is routed to the output channel
// chosen by sel, or copied to all channels in broadcast mode. It replaces
// fixed-size combinational demux trees wherever the downstream consumers can stall.
//
// PARAMETERS
// DATA_W  8  payload width in bits
// N_CH    8  number of output channels, 2..2**SEL_W
// SEL_W   3  select width; sel values >= N_CH are out of range
// CNT_W   8  width of the drop counter
//
// PORTS
// clk        in   1             rising-edge clock
// rst        in   1             synchronous active-high reset
// in_valid   in   1             input word present
// in_ready   out  1             input accepted this cycle when in_valid & in_ready
// in_data    in   DATA_W        payload
// in_sel     in   SEL_W         destination channel, sampled with the payload
// bcast      in   1             1 = deliver to every channel; sampled with the payload
// out_valid  out  N_CH          per-channel word valid, bit k = channel k
// out_ready  in   N_CH          per-channel consumer ready
// out_data   out  N_CH*DATA_W   channel k occupies [k*DATA_W +: DATA_W]
// drop_cnt   out  CNT_W         count of out-of-range words discarded, saturating
//
// BEHAVIOUR
// - Clock is one domain. Reset is synchronous and active-high.
// - Reset, on the rst-high edge: out_valid=0, out_data=0, drop_cnt=0.
// - While rst=1, in_ready=0, so nothing is accepted.
// - Reset mid-transfer discards every held word. There is no partial delivery.
// - free[k] = ~out_valid[k] | out_ready[k], where out_ready[k] is the same-cycle value.
// - in_ready, combinational:
//   - bcast=1: AND of free[0..N_CH-1].
//   - bcast=0 and in_sel<N_CH: free[in_sel].
//   - bcast=0 and in_sel>=N_CH: 1, so the word is always sunk.
// - in_ready may depend on in_sel, bcast and out_ready. It must not depend on in_valid.
// - Accept = in_valid & in_ready. On accept:
//   - bcast=1: every channel loads out_data[k]=in_data and sets out_valid[k]=1.
//     in_sel is ignored.
//   - bcast=0, in range: only channel in_sel loads. Other channels are untouched.
//   - bcast=0, out of range: no channel loads; drop_cnt+=1 and holds at 2**CNT_W-1.
// - Channel register, per cycle:
//   - load: out_valid=1 with the new data. This covers load and drain in the same cycle.
//   - no load, and out_valid & out_ready: out_valid=0; out_data keeps its last value.
//   - otherwise out_valid and out_data hold. Data is stable while valid & ~ready.
// - Latency is exactly 1 cycle from accept to out_valid.
// - Throughput is 1 word/cycle into any single channel whose consumer holds ready=1.
// - A stalled channel blocks only words addressed to it, plus broadcasts.
//   Traffic to other channels keeps flowing.
// - There are no combinational paths from in_* to out_*.
// - N_CH < 2**SEL_W is legal. Unused sel codes are the drop codes.
//
// TESTING
// T1 reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, drop_cnt=0
//    throughout; release -> first accept 1 cycle later.
// T2 routing (N_CH=8): send 0xA0+k with sel=k, k=0..7, all out_ready=1 -> channel k shows
//    0xA0+k one cycle after accept, other channels untouched, 8 words in 8 cycles.
// T3 backpressure: out_ready[3]=0, send 0x11 then 0x22 to sel=3 -> 0x11 held stable,
//    in_ready=0 for 0x22; meanwhile 0x33 to sel=4 accepted; ready[3]=1 -> 0x22 accepted.
// T4 broadcast: bcast=1, data 0x5C, out_ready[6]=0 with ch6 full -> in_ready=0; release
//    ch6 -> accept, all 8 channels out_valid=1 with 0x5C.
// T5 drops: N_CH=6, SEL_W=3, send sel=6,7 repeated 300 times -> all accepted, no out_valid,
//    drop_cnt saturates at 255.
// T6 random: random valid/sel/bcast/out_ready for 10k cycles -> scoreboard per-channel
//    order and data exact; no word lost or duplicated.

Source files
------------

// File: rtl/demux_stream_1ton.sv
// 1:N stream demultiplexer with one registered output slot per channel.
// A word goes to one channel, or to every channel on broadcast, and words addressed to a missing channel are counted and dropped.
module demux_stream_1ton #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     bcast,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam logic [SEL_W:0]   N_CH_CODE = (SEL_W+1)'(N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N_CH-1:0] free_s;
    logic [N_CH-1:0] hit_s;
    logic [N_CH-1:0] load_s;
    logic            in_range_s;
    logic            accept_s;
    logic            drop_s;

    // Channel decode and slot availability; a slot draining this cycle counts as free.
    always_comb begin
        free_s     = ~out_valid | out_ready;
        in_range_s = ({1'b0, in_sel} < N_CH_CODE);
        hit_s      = {N_CH{1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            hit_s[k] = in_range_s & (in_sel == SEL_W'(k));
        end
    end

    // Handshake: out-of-range words are always sunk so they never stall the input.
    always_comb begin
        if (rst) begin
            in_ready = 1'b0;
        end else if (bcast) begin
            in_ready = &free_s;
        end else if (in_range_s) begin
            in_ready = |(free_s & hit_s);
        end else begin
            in_ready = 1'b1;
        end
        accept_s = in_valid & in_ready;
        if (bcast) begin
            load_s = {N_CH{accept_s}};
        end else begin
            load_s = hit_s & {N_CH{accept_s}};
        end
        drop_s = accept_s & ~bcast & ~in_range_s;
    end

    // Per-channel output slots; a load wins over a simultaneous drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= {N_CH{1'b0}};
            out_data  <= {(N_CH*DATA_W){1'b0}};
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (load_s[k]) begin
                    out_valid[k]                  <= 1'b1;
                    out_data[k*DATA_W +: DATA_W]  <= in_data;
                end else if (out_valid[k] & out_ready[k]) begin
                    out_valid[k]                  <= 1'b0;
                end else begin
                    out_valid[k]                  <= out_valid[k];
                end
            end
        end
    end

    // Saturating count of discarded words.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= {CNT_W{1'b0}};
        end else if (drop_s && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + CNT_ONE;
        end else begin
            drop_cnt <= drop_cnt;
        end
    end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: an 8-channel and a 6-channel instance share one stimulus stream.
// Both are checked every cycle against per-channel word queues plus directed tables.
module tb_demux_stream_1ton;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, bcast;
    logic [2:0]  in_sel;
    logic [7:0]  in_data, out_ready;
    logic        rdy8, rdy6;
    logic [7:0]  ov8, dc8, dc6;
    logic [5:0]  ov6;
    logic [63:0] od8;
    logic [47:0] od6;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq    [2][8][$];
    logic [7:0] mlast [2][8];
    int         mcnt  [2];

    typedef struct {
        logic       v;
        logic [2:0] s;
        logic       b;
        logic [7:0] d;
        logic [7:0] ordy;
        logic       exp_rdy;
        logic [7:0] exp_ov;
        int         chk_ch;
        logic [7:0] exp_chd;
    } vec_t;
    vec_t tbl [16];

    demux_stream_1ton #(.DATA_W(8), .N_CH(8), .SEL_W(3), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data),
        .in_sel(in_sel), .bcast(bcast), .out_valid(ov8), .out_ready(out_ready),
        .out_data(od8), .drop_cnt(dc8));

    demux_stream_1ton #(.DATA_W(8), .N_CH(6), .SEL_W(3), .CNT_W(8)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy6), .in_data(in_data),
        .in_sel(in_sel), .bcast(bcast), .out_valid(ov6), .out_ready(out_ready[5:0]),
        .out_data(od6), .drop_cnt(dc6));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic int nch(input int m);
        return (m == 0) ? 8 : 6;
    endfunction

    // A target slot can take a word when it holds nothing or its word leaves this cycle.
    function automatic logic model_ready(input int m);
        if (rst) return 1'b0;
        if (bcast) begin
            for (int k = 0; k < nch(m); k++)
                if (mq[m][k].size() != 0 && !out_ready[k]) return 1'b0;
            return 1'b1;
        end
        if (int'(in_sel) >= nch(m)) return 1'b1;
        return (mq[m][in_sel].size() == 0) || out_ready[in_sel];
    endfunction

    task automatic model_step(input int m, input logic acc);
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                mq[m][k].delete();
                mlast[m][k] = 8'h00;
            end
            mcnt[m] = 0;
        end else begin
            for (int k = 0; k < nch(m); k++)
                if (mq[m][k].size() != 0 && out_ready[k]) void'(mq[m][k].pop_front());
            if (acc) begin
                if (bcast) begin
                    for (int k = 0; k < nch(m); k++) begin
                        mq[m][k].push_back(in_data);
                        mlast[m][k] = in_data;
                    end
                end else if (int'(in_sel) < nch(m)) begin
                    mq[m][in_sel].push_back(in_data);
                    mlast[m][in_sel] = in_data;
                end else if (mcnt[m] < 255) begin
                    mcnt[m]++;
                end
            end
        end
    endtask

    task automatic model_check(input int m);
        logic [7:0] ov_exp;
        logic [7:0] ov_act;
        ov_exp = 8'h00;
        for (int k = 0; k < nch(m); k++) ov_exp[k] = (mq[m][k].size() != 0);
        ov_act = (m == 0) ? ov8 : {2'b00, ov6};
        chk($sformatf("out_valid dut%0d", nch(m)), 64'(ov_act), 64'(ov_exp));
        for (int k = 0; k < nch(m); k++)
            chk($sformatf("out_data dut%0d ch%0d", nch(m), k),
                64'((m == 0) ? od8[k*8 +: 8] : od6[k*8 +: 8]), 64'(mlast[m][k]));
        chk($sformatf("drop_cnt dut%0d", nch(m)), 64'((m == 0) ? dc8 : dc6), 64'(mcnt[m]));
    endtask

    // One clock: drive on the falling edge, check in_ready before the rising edge, outputs after it.
    task automatic cycle(input logic r, input logic v, input logic [2:0] s, input logic b,
                         input logic [7:0] d, input logic [7:0] ordy,
                         output logic r8, output logic r6);
        logic [1:0] acc;
        @(negedge clk);
        rst = r; in_valid = v; in_sel = s; bcast = b; in_data = d; out_ready = ordy;
        #1;
        r8 = rdy8;
        r6 = rdy6;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("in_ready dut%0d", nch(m)), 64'((m == 0) ? rdy8 : rdy6),
                64'(model_ready(m)));
            acc[m] = v & model_ready(m);
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            model_step(m, acc[m]);
            model_check(m);
        end
    endtask

    initial begin
        logic r8, r6;
        int   ok6;

        for (int k = 0; k < 8; k++)
            tbl[k] = '{1'b1, 3'(k), 1'b0, 8'hA0 + 8'(k), 8'hFF, 1'b1, 8'h01 << k, k, 8'hA0 + 8'(k)};
        tbl[8]  = '{1'b1, 3'd2, 1'b0, 8'h5A, 8'h00, 1'b1, 8'h84, 2, 8'h5A};
        tbl[9]  = '{1'b1, 3'd2, 1'b0, 8'h6B, 8'h00, 1'b0, 8'h84, 2, 8'h5A};
        tbl[10] = '{1'b1, 3'd2, 1'b0, 8'h6B, 8'h04, 1'b1, 8'h84, 2, 8'h6B};
        tbl[11] = '{1'b0, 3'd2, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 2, 8'h6B};
        tbl[12] = '{1'b1, 3'd0, 1'b1, 8'hC3, 8'h00, 1'b1, 8'hFF, 5, 8'hC3};
        tbl[13] = '{1'b1, 3'd0, 1'b1, 8'h99, 8'h7F, 1'b0, 8'h80, 7, 8'hC3};
        tbl[14] = '{1'b1, 3'd0, 1'b1, 8'h99, 8'h80, 1'b1, 8'hFF, 0, 8'h99};
        tbl[15] = '{1'b0, 3'd3, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 3, 8'h99};

        rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; bcast = 1'b0;
        in_data = 8'h00; out_ready = 8'h00;
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0;
            for (int k = 0; k < 8; k++) mlast[m][k] = 8'h00;
        end

        // Reset held with a valid word waiting, then the first accept right after release.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 3'd0, 1'b0, 8'h01, 8'hFF, r8, r6);
            chk("t1 in_ready in reset", 64'(r8), 64'd0);
            chk("t1 out_valid in reset", 64'(ov8), 64'd0);
            chk("t1 drop_cnt in reset", 64'(dc6), 64'd0);
        end
        cycle(1'b0, 1'b1, 3'd0, 1'b0, 8'h01, 8'hFF, r8, r6);
        chk("t1 first accept", 64'(r8), 64'd1);
        chk("t1 first out_valid", 64'(ov8), 64'h01);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, r8, r6);

        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, tbl[i].v, tbl[i].s, tbl[i].b, tbl[i].d, tbl[i].ordy, r8, r6);
            chk($sformatf("tbl%0d in_ready", i), 64'(r8), 64'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d out_valid", i), 64'(ov8), 64'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d out_data", i), 64'(od8[tbl[i].chk_ch*8 +: 8]), 64'(tbl[i].exp_chd));
        end

        // Channel 3 stalled: its second word waits while channel 4 keeps flowing.
        cycle(1'b0, 1'b1, 3'd3, 1'b0, 8'h11, 8'hF7, r8, r6);
        chk("t3 accept 0x11", 64'(r8), 64'd1);
        cycle(1'b0, 1'b1, 3'd3, 1'b0, 8'h22, 8'hF7, r8, r6);
        chk("t3 block 0x22", 64'(r8), 64'd0);
        chk("t3 hold 0x11", 64'(od8[31:24]), 64'h11);
        cycle(1'b0, 1'b1, 3'd4, 1'b0, 8'h33, 8'hF7, r8, r6);
        chk("t3 accept 0x33", 64'(r8), 64'd1);
        chk("t3 ch4 data", 64'(od8[39:32]), 64'h33);
        chk("t3 still 0x11", 64'(od8[31:24]), 64'h11);
        cycle(1'b0, 1'b1, 3'd3, 1'b0, 8'h22, 8'hFF, r8, r6);
        chk("t3 accept 0x22", 64'(r8), 64'd1);
        chk("t3 ch3 data", 64'(od8[31:24]), 64'h22);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, r8, r6);

        // Broadcast blocked by a full, stalled channel 6.
        cycle(1'b0, 1'b1, 3'd6, 1'b0, 8'h66, 8'hBF, r8, r6);
        cycle(1'b0, 1'b1, 3'd0, 1'b1, 8'h5C, 8'hBF, r8, r6);
        chk("t4 bcast blocked", 64'(r8), 64'd0);
        cycle(1'b0, 1'b1, 3'd0, 1'b1, 8'h5C, 8'hFF, r8, r6);
        chk("t4 bcast accept", 64'(r8), 64'd1);
        chk("t4 all valid", 64'(ov8), 64'hFF);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t4 ch%0d data", k), 64'(od8[k*8 +: 8]), 64'h5C);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, r8, r6);

        // Reset while a word is held discards it.
        cycle(1'b0, 1'b1, 3'd1, 1'b0, 8'h77, 8'h00, r8, r6);
        cycle(1'b1, 1'b1, 3'd1, 1'b0, 8'h88, 8'h00, r8, r6);
        chk("reset mid in_ready", 64'(r8), 64'd0);
        chk("reset mid out_valid", 64'(ov8), 64'd0);
        chk("reset mid out_data", od8, 64'd0);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, r8, r6);

        // Drop codes on the 6-channel instance until the counter saturates.
        ok6 = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b1, (i % 2 == 1) ? 3'd7 : 3'd6, 1'b0, 8'(i), 8'hFF, r8, r6);
            if (r6) ok6++;
        end
        chk("t5 drops accepted", 64'(ok6), 64'd300);
        chk("t5 drop_cnt sat", 64'(dc6), 64'd255);
        chk("t5 no out_valid", 64'(ov6), 64'd0);

        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), 3'($urandom),
                  ($urandom_range(0, 7) == 0), 8'($urandom), 8'($urandom | $urandom), r8, r6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
